// File: rtl/aes_round_key_cache.sv
// Round-key cache: drives key_expansion through one full schedule and keeps all
// Nr+1 round keys in a local register file for random, forward or inverse reads.
module aes_round_key_cache #(
    parameter int unsigned MAX_KEYS = 15,
    parameter int unsigned IDX_W    = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [255:0]       key,
    output logic               exp_load,
    output logic               exp_revers,
    output logic [1:0]         exp_mode,
    output logic [255:0]       exp_key,
    input  logic [127:0]       exp_round_key,
    input  logic [4:0]         exp_round,
    output logic               busy,
    output logic               keys_valid,
    input  logic               rd_en,
    input  logic               rd_inverse,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [127:0]       rd_key,
    output logic               rd_valid,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE
    } state_e;

    state_e             state_q;
    logic [1:0]         mode_q;
    logic [255:0]       key_q;
    logic [IDX_W-1:0]   cnt_q;
    logic               desync_q;
    logic               exp_load_q;
    logic               busy_q;
    logic               keys_valid_q;
    logic [127:0]       rd_key_q;
    logic               rd_valid_q;
    logic               err_q;
    logic [127:0]       mem_q [MAX_KEYS];

    logic [IDX_W-1:0]   nr;
    logic               can_start;
    logic               start_ok;
    logic               start_bad;
    logic               rd_ok;
    logic               rd_bad;
    logic [IDX_W-1:0]   rd_phys;
    logic               desync_hit;

    // Last round index for the latched key size
    function automatic logic [IDX_W-1:0] nr_of(input logic [1:0] m);
        case (m)
            2'd0:    nr_of = IDX_W'(10);
            2'd1:    nr_of = IDX_W'(12);
            default: nr_of = IDX_W'(14);
        endcase
    endfunction

    always_comb begin
        nr         = nr_of(mode_q);
        can_start  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        start_ok   = start && can_start && (mode != 2'd3);
        start_bad  = start && can_start && (mode == 2'd3);
        rd_ok      = rd_en && (state_q == ST_DONE) && (rd_idx <= nr);
        rd_bad     = rd_en && !rd_ok;
        rd_phys    = rd_inverse ? (nr - rd_idx) : rd_idx;
        desync_hit = (state_q == ST_FILL) && (exp_round != 5'(cnt_q));
    end

    // Control FSM with registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'd0;
            key_q        <= '0;
            cnt_q        <= '0;
            desync_q     <= 1'b0;
            exp_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q     <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            exp_load_q <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= start_bad | rd_bad;

            if (rd_ok) begin
                rd_key_q   <= mem_q[rd_phys];
                rd_valid_q <= 1'b1;
            end else if (rd_bad) begin
                rd_key_q   <= '0;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        mode_q       <= mode;
                        key_q        <= key;
                        desync_q     <= 1'b0;
                        exp_load_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        keys_valid_q <= 1'b0;
                        state_q      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_FILL;
                end
                ST_FILL: begin
                    cnt_q <= cnt_q + IDX_W'(1);
                    // Report only the first mismatch of a fill; the write happens regardless
                    if (desync_hit) begin
                        desync_q <= 1'b1;
                        if (!desync_q) begin
                            err_q <= 1'b1;
                        end
                    end
                    if (cnt_q == nr) begin
                        busy_q       <= 1'b0;
                        keys_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Register file has no reset; contents only matter once a fill completes
    always_ff @(posedge CLK) begin
        if (state_q == ST_FILL) begin
            mem_q[cnt_q] <= exp_round_key;
        end
    end

    assign exp_load   = exp_load_q;
    assign exp_revers = 1'b0;
    assign exp_mode   = mode_q;
    assign exp_key    = key_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;
    assign rd_valid   = rd_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_aes_round_key_cache.sv
// Bench for aes_round_key_cache: AES key-schedule stub, cycle-level reference model,
// directed FIPS-197 vectors and randomized traffic.
module tb_aes_round_key_cache;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK0    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key;
    logic         exp_load;
    logic         exp_revers;
    logic [1:0]   exp_mode;
    logic [255:0] exp_key;
    logic [127:0] exp_round_key;
    logic [4:0]   exp_round;
    logic         busy;
    logic         keys_valid;
    logic         rd_en;
    logic         rd_inverse;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         err;

    int checks = 0;
    int errors = 0;

    aes_round_key_cache dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .mode(mode), .key(key),
        .exp_load(exp_load), .exp_revers(exp_revers), .exp_mode(exp_mode), .exp_key(exp_key),
        .exp_round_key(exp_round_key), .exp_round(exp_round),
        .busy(busy), .keys_valid(keys_valid),
        .rd_en(rd_en), .rd_inverse(rd_inverse), .rd_idx(rd_idx),
        .rd_key(rd_key), .rd_valid(rd_valid), .err(err)
    );

    always #5 CLK = ~CLK;

    // ---------------- AES key schedule reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int j = 1; j < 256; j++) if (gmul(a, 8'(j)) == 8'h01) inv = 8'(j);
        return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    endfunction

    initial for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Round key i lives at bits [i*128 +: 128]; the cipher key is MSB-aligned in the 256-bit port
    function automatic logic [1919:0] aes_expand(input logic [255:0] k, input logic [1:0] m);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int nk;
        int nrr;
        nk  = (m == 2'd0) ? 4 : (m == 2'd1) ? 6 : 8;
        nrr = nk + 6;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nrr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        r = '0;
        for (int i = 0; i <= nrr; i++) r[i*128 +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        return r;
    endfunction

    function automatic int nr_of(input logic [1:0] m);
        return (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
    endfunction

    // ---------------- key_expansion stub ----------------
    logic          stub_stuck = 1'b0;
    logic [4:0]    stub_round = 5'd0;
    logic [1919:0] stub_tab = '0;

    always_ff @(posedge CLK) begin
        if (exp_load) begin
            stub_tab   <= aes_expand(exp_key, exp_mode);
            stub_round <= 5'd0;
        end else if (stub_round != 5'd31) begin
            stub_round <= stub_round + 5'd1;
        end
    end

    assign exp_round = stub_stuck ? 5'd0 : stub_round;
    always_comb exp_round_key = stub_tab[((stub_round > 5'd14) ? 14 : int'(stub_round))*128 +: 128];

    // ---------------- reference model ----------------
    int            m_left = 0;
    bit            m_valid = 1'b0;
    bit            m_desync = 1'b0;
    int            m_nr = 10;
    logic [1:0]    m_mode = 2'd0;
    logic [255:0]  m_key = '0;
    logic [1919:0] m_tab = '0;
    logic          e_load = 1'b0;
    logic          e_err = 1'b0;
    logic          e_rdv = 1'b0;
    logic          e_chk = 1'b0;
    logic [127:0]  e_rdkey = '0;

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            m_left = 0; m_valid = 1'b0; m_desync = 1'b0; m_nr = 10; m_mode = 2'd0; m_key = '0;
            e_load = 1'b0; e_err = 1'b0; e_rdv = 1'b0; e_chk = 1'b0; e_rdkey = '0;
        end else begin
            e_err = 1'b0; e_rdv = 1'b0; e_chk = 1'b0; e_load = 1'b0;
            if (rd_en) begin
                e_chk = 1'b1;
                if (m_valid && int'(rd_idx) <= m_nr) begin
                    e_rdv   = 1'b1;
                    e_rdkey = m_tab[(rd_inverse ? m_nr - int'(rd_idx) : int'(rd_idx))*128 +: 128];
                end else begin
                    e_err   = 1'b1;
                    e_rdkey = '0;
                end
            end
            if (m_left > 0) begin
                // Edges after acceptance: one load edge, then writes of rounds 0..Nr
                m_left--;
                if (m_left <= m_nr) begin
                    if (stub_stuck && (m_nr - m_left) != 0) begin
                        if (!m_desync) e_err = 1'b1;
                        m_desync = 1'b1;
                    end
                    if (m_left == 0) m_valid = 1'b1;
                end
            end else if (start) begin
                if (mode == 2'd3) begin
                    e_err = 1'b1;
                end else begin
                    m_mode = mode; m_key = key; m_nr = nr_of(mode);
                    m_tab = aes_expand(key, mode);
                    m_left = m_nr + 2; m_valid = 1'b0; m_desync = 1'b0; e_load = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge CLK);
        chk("busy", 256'(busy), 256'(m_left > 0));
        chk("keys_valid", 256'(keys_valid), 256'(m_valid));
        chk("exp_load", 256'(exp_load), 256'(e_load));
        chk("exp_revers", 256'(exp_revers), 256'(0));
        chk("exp_mode", 256'(exp_mode), 256'(m_mode));
        chk("exp_key", exp_key, m_key);
        chk("rd_valid", 256'(rd_valid), 256'(e_rdv));
        chk("err", 256'(err), 256'(e_err));
        if (e_chk) chk("rd_key", 256'(rd_key), 256'(e_rdkey));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input logic [1:0] md, input logic [255:0] k, input string nm);
        int n;
        start = 1'b1; mode = md; key = k;
        tick();
        start = 1'b0;
        n = 0;
        while (!keys_valid && n < 40) begin tick(); n++; end
        chk({nm, " latency"}, 256'(n), 256'(nr_of(md) + 2));
    endtask

    task automatic do_read(input logic inv, input logic [3:0] idx, input logic [127:0] lit, input string nm);
        rd_en = 1'b1; rd_inverse = inv; rd_idx = idx;
        tick();
        rd_en = 1'b0;
        chk({nm, " rd_valid"}, 256'(rd_valid), 256'(1));
        chk({nm, " rd_key"}, 256'(rd_key), 256'(lit));
    endtask

    initial begin
        logic [1919:0] tab;
        int n;
        int first;
        int nerr;

        RST_N = 1'b1; start = 1'b0; mode = 2'd0; key = '0;
        rd_en = 1'b0; rd_inverse = 1'b0; rd_idx = 4'd0;
        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        tab = aes_expand(K128, 2'd0);
        chk("model aes128 rk1", 256'(tab[1*128 +: 128]), 256'(RK1));
        chk("model aes128 rk10", 256'(tab[10*128 +: 128]), 256'(RK10));
        tab = aes_expand(K256, 2'd2);
        chk("model aes256 rk14", 256'(tab[14*128 +: 128]), 256'(RK14_256));

        start = 1'b1; mode = 2'd3; key = K128;
        tick();
        start = 1'b0;
        chk("idle mode3 err", 256'(err), 256'(1));
        chk("idle mode3 busy", 256'(busy), 256'(0));
        tick();

        fill(2'd0, K128, "aes128");
        do_read(1'b0, 4'd0, RK0, "fwd0");
        do_read(1'b0, 4'd1, RK1, "fwd1");
        do_read(1'b0, 4'd10, RK10, "fwd10");
        do_read(1'b1, 4'd0, RK10, "inv0");
        do_read(1'b1, 4'd10, RK0, "inv10");

        rd_en = 1'b1; rd_inverse = 1'b0; rd_idx = 4'd11;
        tick();
        rd_en = 1'b0;
        chk("idx11 err", 256'(err), 256'(1));
        chk("idx11 rd_valid", 256'(rd_valid), 256'(0));
        chk("idx11 rd_key", 256'(rd_key), 256'(0));

        start = 1'b1; mode = 2'd3;
        tick();
        start = 1'b0;
        chk("done mode3 err", 256'(err), 256'(1));
        chk("done mode3 keys_valid", 256'(keys_valid), 256'(1));
        do_read(1'b0, 4'd10, RK10, "retained10");

        rd_en = 1'b1; rd_idx = 4'd10; start = 1'b1; mode = 2'd2; key = K256;
        tick();
        rd_en = 1'b0; start = 1'b0;
        chk("read+start rd_key", 256'(rd_key), 256'(RK10));
        chk("read+start busy", 256'(busy), 256'(1));
        chk("read+start keys_valid", 256'(keys_valid), 256'(0));
        tick();
        rd_en = 1'b1; rd_idx = 4'd0;
        tick();
        rd_en = 1'b0;
        chk("fill read err", 256'(err), 256'(1));
        n = 0;
        while (!keys_valid && n < 40) begin tick(); n++; end
        chk("aes256 first fill done", 256'(keys_valid), 256'(1));

        fill(2'd2, K256, "aes256");
        do_read(1'b0, 4'd14, RK14_256, "aes256 fwd14");
        do_read(1'b1, 4'd0, RK14_256, "aes256 inv0");

        stub_stuck = 1'b1;
        start = 1'b1; mode = 2'd0; key = K128;
        tick();
        start = 1'b0;
        n = 0; first = -1; nerr = 0;
        while (!keys_valid && n < 40) begin
            tick(); n++;
            if (err) begin nerr++; if (first < 0) first = n; end
        end
        stub_stuck = 1'b0;
        chk("desync err edge", 256'(first), 256'(3));
        chk("desync err count", 256'(nerr), 256'(1));
        chk("desync latency", 256'(n), 256'(12));

        start = 1'b1; mode = 2'd0; key = K128;
        tick();
        start = 1'b0;
        n = 0;
        while (!keys_valid && n < 40) begin
            if (n == 3) begin start = 1'b1; mode = 2'd2; key = K256; end
            tick(); n++;
            start = 1'b0;
        end
        chk("busy start latency", 256'(n), 256'(12));
        chk("busy start mode", 256'(exp_mode), 256'(0));

        start = 1'b1; mode = 2'd0; key = K128;
        tick();
        start = 1'b0;
        repeat (6) tick();
        RST_N = 1'b0;
        #1;
        chk("midfill reset busy", 256'(busy), 256'(0));
        chk("midfill reset keys_valid", 256'(keys_valid), 256'(0));
        tick();
        RST_N = 1'b1;
        fill(2'd0, K128, "restart");
        do_read(1'b0, 4'd10, RK10, "restart idx10");

        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 19) == 0);
            mode = 2'($urandom_range(0, 3));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rd_en = 1'($urandom_range(0, 1));
            rd_inverse = 1'($urandom_range(0, 1));
            rd_idx = 4'($urandom_range(0, 15));
            stub_stuck = ($urandom_range(0, 15) == 0);
            tick();
        end
        start = 1'b0; rd_en = 1'b0; stub_stuck = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
